// File: rtl/mem_access_ctrl_if.sv
// Data-memory port between the MEM-stage controller (master) and the memory (slave).
// A request is held until the memory answers with a single-cycle ack.
interface mem_access_ctrl_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: issues one req/ack memory access per instruction and stalls
// the pipeline until it completes, refuses misaligned/illegal ops, and times out.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_mem_read,
    input  logic                      i_mem_write,
    input  logic [2:0]                i_mem_op,
    input  logic [31:0]               i_addr,
    input  logic [31:0]               i_wdata,
    mem_access_ctrl_if.master         dmem,
    output logic                      o_mem_stall,
    output logic [31:0]               o_load_data,
    output logic                      o_misalign,
    output logic                      o_bus_err
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state, w_next;
    logic        r_req, r_we, r_bus_err;
    logic [31:0] r_addr, r_wdata, r_load_data;
    logic [3:0]  r_be;
    logic [2:0]  r_op;
    logic [1:0]  r_off;
    logic [7:0]  r_cnt;

    logic        w_access, w_illegal, w_start, w_ack, w_tmo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_sh, w_ext;

    assign w_access = i_mem_read | i_mem_write;

    // A store with mem_op[2] set (unsigned variant) has no meaning and is refused.
    always_comb begin
        w_illegal = 1'b1;
        case (i_mem_op)
            3'b000:  w_illegal = 1'b0;
            3'b001:  w_illegal = i_addr[0];
            3'b010:  w_illegal = |i_addr[1:0];
            3'b100:  w_illegal = i_mem_write;
            3'b101:  w_illegal = i_mem_write | i_addr[0];
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_wdata;
        case (i_mem_op[1:0])
            2'b00: begin
                w_be    = 4'b0001 << i_addr[1:0];
                w_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_sh = dmem.dmem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_ext = w_sh;
        case (r_op)
            3'b000:  w_ext = {{24{w_sh[7]}}, w_sh[7:0]};
            3'b100:  w_ext = {24'h0, w_sh[7:0]};
            3'b001:  w_ext = {{16{w_sh[15]}}, w_sh[15:0]};
            3'b101:  w_ext = {16'h0, w_sh[15:0]};
            default: w_ext = w_sh;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Stall in IDLE is gated by reset so an asserted reset releases the pipeline at once.
    always_comb begin
        w_next      = r_state;
        o_mem_stall = 1'b0;
        w_start     = 1'b0;
        w_ack       = 1'b0;
        w_tmo       = 1'b0;
        o_misalign  = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_misalign = w_access & w_illegal;
                if (w_access && !w_illegal && rst) begin
                    w_start     = 1'b1;
                    o_mem_stall = 1'b1;
                    w_next      = S_BUSY;
                end
            end
            S_BUSY: begin
                o_mem_stall = 1'b1;
                if (dmem.dmem_ack) begin
                    w_ack  = 1'b1;
                    w_next = S_DONE;
                end else if (r_cnt == LP_TMO_LAST) begin
                    w_tmo  = 1'b1;
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_op        <= '0;
            r_off       <= '0;
            r_load_data <= '0;
            r_bus_err   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_bus_err <= 1'b0;
            if (w_start) begin
                r_req   <= 1'b1;
                r_we    <= i_mem_write;
                r_addr  <= {i_addr[31:2], 2'b00};
                r_be    <= w_be;
                r_wdata <= w_wdata;
                r_op    <= i_mem_op;
                r_off   <= i_addr[1:0];
            end
            if (w_ack) begin
                r_req       <= 1'b0;
                r_load_data <= w_ext;
            end else if (w_tmo) begin
                r_req       <= 1'b0;
                r_load_data <= '0;
                r_bus_err   <= 1'b1;
            end
            if (r_state == S_BUSY && w_next == S_BUSY) r_cnt <= r_cnt + 8'd1;
            else                                      r_cnt <= '0;
        end
    end

    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_be    = r_be;
    assign dmem.dmem_wdata = r_wdata;
    assign o_load_data     = r_load_data;
    assign o_bus_err       = r_bus_err;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: vector table driven through a scoreboard, with a
// bench-side memory responder, plus hand-written reset / stray-ack sequences.
module tb_mem_access_ctrl;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd, wr;
    logic [2:0]  op;
    logic [31:0] addr, wdata;
    logic        stall, misal, berr;
    logic [31:0] ld;

    always #5 clk = ~clk;

    mem_access_ctrl_if bus();

    mem_access_ctrl #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_mem_read  (rd),
        .i_mem_write (wr),
        .i_mem_op    (op),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .dmem        (bus),
        .o_mem_stall (stall),
        .o_load_data (ld),
        .o_misalign  (misal),
        .o_bus_err   (berr)
    );

    typedef struct {
        logic        rd, wr;
        logic [2:0]  op;
        logic [31:0] addr, wdata, rdata;
        int          waits;     // -1: memory never acks
        logic        mis, we;
        logic [3:0]  be;
        logic [31:0] bwdata;
        logic        ckld;
        logic [31:0] ld;
        logic        berr;
    } vec_t;

    vec_t tv[$];
    vec_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic w, input logic [2:0] o,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                                input int wt, input logic m, input logic we, input logic [3:0] be,
                                input logic [31:0] bwd, input logic ck, input logic [31:0] l,
                                input logic be_err);
        vec_t v;
        v.rd = r; v.wr = w; v.op = o; v.addr = a; v.wdata = wd; v.rdata = rdat;
        v.waits = wt; v.mis = m; v.we = we; v.be = be; v.bwdata = bwd;
        v.ckld = ck; v.ld = l; v.berr = be_err;
        return v;
    endfunction

    task automatic run(input vec_t v, input int idx);
        vec_t  e;
        int    reqc, stc, n;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        rd = v.rd; wr = v.wr; op = v.op; addr = v.addr; wdata = v.wdata;
        #1;
        chk({tag, ".misalign"}, 32'(misal), 32'(v.mis));
        if (v.mis) begin
            chk({tag, ".stall_refused"}, 32'(stall), 32'd0);
            @(posedge clk); #1;
            chk({tag, ".no_req"}, 32'(bus.dmem_req), 32'd0);
            rd = 1'b0; wr = 1'b0;
            return;
        end
        sb.push_back(v);
        stc  = stall ? 1 : 0;
        reqc = 0;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (!bus.dmem_req) break;
            reqc++;
            if (stall) stc++;
            bus.dmem_ack   = (v.waits >= 0) && (reqc - 1 == v.waits);
            bus.dmem_rdata = bus.dmem_ack ? v.rdata : $urandom;
        end
        bus.dmem_ack = 1'b0;
        if (n == 50) begin
            total++; bad++;
            $display("FAIL %s.done: access never completed within 50 cycles", tag);
        end
        e = sb.pop_front();
        chk({tag, ".addr"},  bus.dmem_addr, {e.addr[31:2], 2'b00});
        chk({tag, ".we"},    32'(bus.dmem_we), 32'(e.we));
        chk({tag, ".be"},    32'(bus.dmem_be), 32'(e.be));
        chk({tag, ".wdata"}, bus.dmem_wdata, e.bwdata);
        chk({tag, ".stall_done"}, 32'(stall), 32'd0);
        chk({tag, ".bus_err"}, 32'(berr), 32'(e.berr));
        if (e.ckld) chk({tag, ".load_data"}, ld, e.ld);
        chk({tag, ".req_cycles"}, 32'(reqc), 32'((e.waits < 0) ? TMO : e.waits + 1));
        chk({tag, ".stall_cycles"}, 32'(stc), 32'(reqc + 1));
        rd = 1'b0; wr = 1'b0; op = 3'b000; addr = '0; wdata = '0;
        @(negedge clk);
        chk({tag, ".bus_err_clr"}, 32'(berr), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; rd = 1'b0; wr = 1'b0; op = '0; addr = '0; wdata = '0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;

        //        rd wr op      addr      wdata         rdata        wt  mis we be       bwdata        ck ld            berr
        tv.push_back(mk(1, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 0, 4'b1111, 32'h0,        1, 32'hDEADBEEF, 0));
        tv.push_back(mk(1, 0, 3'b000, 32'h103, 32'h0,        32'h80AABBCC, 0, 0, 0, 4'b1000, 32'h0,        1, 32'hFFFFFF80, 0));
        tv.push_back(mk(1, 0, 3'b100, 32'h103, 32'h0,        32'h80AABBCC, 1, 0, 0, 4'b1000, 32'h0,        1, 32'h00000080, 0));
        tv.push_back(mk(1, 0, 3'b001, 32'h102, 32'h0,        32'h80AABBCC, 0, 0, 0, 4'b1100, 32'h0,        1, 32'hFFFF80AA, 0));
        tv.push_back(mk(1, 0, 3'b101, 32'h102, 32'h0,        32'h80AABBCC, 2, 0, 0, 4'b1100, 32'h0,        1, 32'h000080AA, 0));
        tv.push_back(mk(1, 0, 3'b000, 32'h101, 32'h0,        32'h80AABBCC, 0, 0, 0, 4'b0010, 32'h0,        1, 32'hFFFFFFBB, 0));
        tv.push_back(mk(1, 0, 3'b001, 32'h100, 32'h0,        32'h12347FFE, 0, 0, 0, 4'b0011, 32'h0,        1, 32'h00007FFE, 0));
        tv.push_back(mk(0, 1, 3'b000, 32'h201, 32'h12345678, 32'h0,        0, 0, 1, 4'b0010, 32'h78787878, 0, 32'h0,        0));
        tv.push_back(mk(0, 1, 3'b001, 32'h202, 32'h12345678, 32'h0,        0, 0, 1, 4'b1100, 32'h56785678, 0, 32'h0,        0));
        tv.push_back(mk(0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0,        2, 0, 1, 4'b1111, 32'hCAFEF00D, 0, 32'h0,        0));
        tv.push_back(mk(1, 1, 3'b000, 32'h200, 32'h000000AB, 32'h0,        0, 0, 1, 4'b0001, 32'hABABABAB, 0, 32'h0,        0));
        tv.push_back(mk(1, 0, 3'b010, 32'h102, 32'h0,        32'h0,        0, 1, 0, 4'b0000, 32'h0,        0, 32'h0,        0));
        tv.push_back(mk(0, 1, 3'b001, 32'h001, 32'h0,        32'h0,        0, 1, 0, 4'b0000, 32'h0,        0, 32'h0,        0));
        tv.push_back(mk(1, 0, 3'b011, 32'h000, 32'h0,        32'h0,        0, 1, 0, 4'b0000, 32'h0,        0, 32'h0,        0));
        tv.push_back(mk(1, 0, 3'b110, 32'h000, 32'h0,        32'h0,        0, 1, 0, 4'b0000, 32'h0,        0, 32'h0,        0));
        tv.push_back(mk(0, 1, 3'b100, 32'h000, 32'h0,        32'h0,        0, 1, 0, 4'b0000, 32'h0,        0, 32'h0,        0));
        tv.push_back(mk(1, 0, 3'b010, 32'h101, 32'h0,        32'h0,        0, 1, 0, 4'b0000, 32'h0,        0, 32'h0,        0));
        tv.push_back(mk(1, 0, 3'b010, 32'h300, 32'h0,        32'h0,       -1, 0, 0, 4'b1111, 32'h0,        1, 32'h0,        1));
        tv.push_back(mk(1, 0, 3'b010, 32'h304, 32'h0,        32'h11223344, 3, 0, 0, 4'b1111, 32'h0,        1, 32'h11223344, 0));
        tv.push_back(mk(1, 0, 3'b101, 32'h306, 32'h0,        32'h8899AABB, 0, 0, 0, 4'b1100, 32'h0,        1, 32'h00008899, 0));

        repeat (2) @(negedge clk);
        chk("rst.req",   32'(bus.dmem_req), 32'd0);
        chk("rst.be",    32'(bus.dmem_be),  32'd0);
        chk("rst.addr",  bus.dmem_addr,     32'd0);
        chk("rst.wdata", bus.dmem_wdata,    32'd0);
        chk("rst.ld",    ld,                32'd0);
        chk("rst.berr",  32'(berr),         32'd0);
        chk("rst.stall", 32'(stall),        32'd0);
        rst = 1'b1;

        for (int i = 0; i < tv.size(); i++) run(tv[i], i);

        // A stray ack while idle must not disturb load_data or start anything.
        @(negedge clk);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        bus.dmem_ack = 1'b0;
        #1;
        chk("stray_ack.ld",  ld, 32'h00008899);
        chk("stray_ack.req", 32'(bus.dmem_req), 32'd0);

        // Reset asserted mid-access with the load still presented.
        @(negedge clk);
        rd = 1'b1; op = 3'b010; addr = 32'h400;
        @(negedge clk);
        chk("midrst.busy_req", 32'(bus.dmem_req), 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst.req",   32'(bus.dmem_req), 32'd0);
        chk("midrst.stall", 32'(stall), 32'd0);
        chk("midrst.ld",    ld, 32'd0);
        rd = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run(mk(1, 0, 3'b010, 32'h404, 32'h0, 32'h5A5AA5A5, 1, 0, 0, 4'b1111, 32'h0, 1, 32'h5A5AA5A5, 0), 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
